// File: rtl/cmd_ctrl_pkg.sv
// Shared constants for the command dispatcher: ASCII response words, FSM states
// and the bit layout of a {instr, reg, time} command.
package cmd_ctrl_pkg;

  localparam logic [31:0] RESP_BSY = 32'h0D595342;
  localparam logic [31:0] RESP_OK  = 32'h0D0A4B4F;
  localparam logic [31:0] RESP_R0  = 32'h0D0A2030;
  localparam logic [31:0] RESP_R1  = 32'h0D0A2031;
  localparam logic [31:0] RESP_ER  = 32'h0D0A5245;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE,
    RESP
  } state_t;

  localparam int CMD_TIME_LSB  = 0;
  localparam int CMD_REG_LSB   = 32;
  localparam int CMD_INSTR_LSB = 37;
  localparam int CMD_READ_BIT  = 2;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; a pop in the same cycle frees a slot for a push,
// so a full FIFO can accept a new entry while it is being drained.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cmd_dispatch_ctrl.sv
// Command dispatcher: queues incoming commands, runs the IO issue/busy/done
// handshake with a timeout and emits one ASCII response word per command.
module cmd_dispatch_ctrl
  import cmd_ctrl_pkg::*;
#(
  parameter int INPUT_DATA_SIZE    = 40,
  parameter int WORD_SIZE          = 32,
  parameter int INSTRUCTION_SIZE   = 3,
  parameter int SIZE_WORD_REGISTER = 5,
  parameter int SIZE_WORD          = 3,
  parameter int FIFO_DEPTH         = 4,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [INPUT_DATA_SIZE-1:0]      control_value,
  input  logic                            valid_control_value,
  input  logic                            busy_sender_data,
  input  logic                            busy_io_module,
  input  logic                            result_input_io,
  output logic [SIZE_WORD-1:0]            size_line,
  output logic [WORD_SIZE-1:0]            send_data_register,
  output logic                            valid_data,
  output logic [INSTRUCTION_SIZE-1:0]     instrucction,
  output logic [SIZE_WORD_REGISTER-1:0]   register,
  output logic [WORD_SIZE-1:0]            clock_time,
  output logic                            valid_instrucction,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            timeout_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  state_t                     state, state_next;
  logic [TW-1:0]              timer;
  logic                       timed_out;
  logic                       result_q;
  logic                       reject_pending;
  logic [INPUT_DATA_SIZE-1:0] fifo_dout;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       fifo_pop;
  logic                       fifo_reject;
  logic                       issue;
  logic                       send_bsy;
  logic                       send_resp;
  logic                       timeout_hit;
  logic                       done_hit;
  logic                       timer_expired;
  logic [WORD_SIZE-1:0]       resp_word;

  cmd_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(INPUT_DATA_SIZE)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (valid_control_value),
    .pop   (fifo_pop),
    .din   (control_value),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign timer_expired = (timer == TW'(TIMEOUT_CYCLES - 1));
  assign fifo_reject   = valid_control_value && fifo_full && !fifo_pop;
  assign size_line     = SIZE_WORD'(4);

  always_comb begin
    state_next  = state;
    fifo_pop    = 1'b0;
    issue       = 1'b0;
    send_bsy    = 1'b0;
    send_resp   = 1'b0;
    timeout_hit = 1'b0;
    done_hit    = 1'b0;
    case (state)
      IDLE: begin
        if (reject_pending && !busy_sender_data) begin
          send_bsy = 1'b1;
        end else if (!fifo_empty && !busy_io_module) begin
          fifo_pop   = 1'b1;
          issue      = 1'b1;
          state_next = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (timer_expired) begin
          timeout_hit = 1'b1;
          state_next  = RESP;
        end else if (busy_io_module) begin
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (timer_expired) begin
          timeout_hit = 1'b1;
          state_next  = RESP;
        end else if (!busy_io_module) begin
          done_hit   = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (!busy_sender_data) begin
          send_resp  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    resp_word = WORD_SIZE'(RESP_OK);
    if (timed_out)                      resp_word = WORD_SIZE'(RESP_ER);
    else if (instrucction[CMD_READ_BIT]) resp_word = result_q ? WORD_SIZE'(RESP_R1) : WORD_SIZE'(RESP_R0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      timer          <= '0;
      timed_out      <= 1'b0;
      result_q       <= 1'b0;
      reject_pending <= 1'b0;
      timeout_error  <= 1'b0;
    end else begin
      state <= state_next;
      if (issue) timer <= '0;
      else if (state == WAIT_BUSY || state == WAIT_DONE) timer <= timer + TW'(1);
      if (issue)            timed_out <= 1'b0;
      else if (timeout_hit) timed_out <= 1'b1;
      if (done_hit) result_q <= result_input_io;
      if (timeout_hit) timeout_error <= 1'b1;
      // A drop in the same cycle BSY goes out is reported by that same BSY.
      if (send_bsy)         reject_pending <= 1'b0;
      else if (fifo_reject) reject_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_instrucction <= 1'b0;
      instrucction       <= '0;
      register           <= '0;
      clock_time         <= '0;
      valid_data         <= 1'b0;
      send_data_register <= '0;
    end else begin
      valid_instrucction <= issue;
      if (issue) begin
        instrucction <= fifo_dout[CMD_INSTR_LSB +: INSTRUCTION_SIZE];
        register     <= fifo_dout[CMD_REG_LSB +: SIZE_WORD_REGISTER];
        clock_time   <= fifo_dout[CMD_TIME_LSB +: WORD_SIZE];
      end
      valid_data <= send_bsy || send_resp;
      if (send_bsy)       send_data_register <= WORD_SIZE'(RESP_BSY);
      else if (send_resp) send_data_register <= resp_word;
    end
  end

endmodule
